// File: rtl/loop_controller_if.sv
// Decode/fetch-side signal bundle for the loop controller.
// No valid/ready pair exists here: the bracket strobes, cell_zero and pc are qualified by the
// cycle they appear in, stall_in=0 is the only acceptance condition, and a stalled cycle
// is presented again unchanged.
interface loop_controller_if #(
    parameter int PC_WIDTH    = 16,
    parameter int STACK_DEPTH = 16
);
    localparam int LEVEL_WIDTH = $clog2(STACK_DEPTH + 1);

    logic [PC_WIDTH-1:0]    pc;
    logic                   is_open;
    logic                   is_close;
    logic                   cell_zero;
    logic                   stall_in;
    logic                   pc_write;
    logic                   pc_src;
    logic [PC_WIDTH-1:0]    pc_loaded;
    logic                   squash;
    logic [LEVEL_WIDTH-1:0] loop_level;
    logic                   overflow;
    logic                   underflow;
    logic [1:0]             fsm_state;   // debug view: 0 RUN, 1 SCAN, 2 ERR

    modport master (
        input  pc, is_open, is_close, cell_zero, stall_in,
        output pc_write, pc_src, pc_loaded, squash, loop_level, overflow, underflow, fsm_state
    );

    modport slave (
        output pc, is_open, is_close, cell_zero, stall_in,
        input  pc_write, pc_src, pc_loaded, squash, loop_level, overflow, underflow, fsm_state
    );
endinterface

// File: rtl/loop_controller.sv
// Loop sequencer for '[' / ']': return-address stack for taken loops, single-cycle back
// branches, and a forward bracket-matching scan when '[' meets a zero cell.
module loop_controller #(
    parameter int PC_WIDTH    = 16,
    parameter int STACK_DEPTH = 16,
    parameter int SCAN_WIDTH  = 8
) (
    input logic               clk,
    input logic               reset,
    loop_controller_if.master bus
);
    localparam int SP_WIDTH  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_WIDTH-1:0]   SP_FULL   = SP_WIDTH'(STACK_DEPTH);
    localparam logic [SCAN_WIDTH-1:0] DEPTH_MAX = '1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SCAN = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PC_WIDTH-1:0]     stack [STACK_DEPTH];
    logic [SP_WIDTH-1:0]     sp;
    logic [SP_WIDTH-1:0]     sp_m1;
    logic [SCAN_WIDTH-1:0]   depth;
    logic [SCAN_WIDTH-1:0]   depth_nxt;
    logic                    overflow_r;
    logic                    underflow_r;
    logic                    stack_full;
    logic                    stack_empty;
    logic [PC_WIDTH-1:0]     top;
    logic                    do_push;
    logic                    do_pop;
    logic                    set_ovf;
    logic                    set_unf;
    logic                    write_c;
    logic                    src_c;
    logic                    squash_c;

    assign stack_full  = (sp == SP_FULL);
    assign stack_empty = (sp == '0);
    assign sp_m1       = sp - SP_WIDTH'(1);
    assign top         = stack_empty ? '0 : stack[sp_m1[IDX_WIDTH-1:0]];

    // Decision for the instruction currently at pc; '[' takes priority over ']'.
    always_comb begin
        write_c   = 1'b1;
        src_c     = 1'b0;
        squash_c  = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        state_nxt = state;
        depth_nxt = depth;
        case (state)
            RUN: begin
                if (bus.is_open) begin
                    if (!bus.cell_zero) begin
                        if (!stack_full) begin
                            do_push = 1'b1;
                        end else begin
                            set_ovf   = 1'b1;
                            state_nxt = ERR;
                            write_c   = 1'b0;
                        end
                    end else begin
                        squash_c  = 1'b1;
                        depth_nxt = SCAN_WIDTH'(1);
                        state_nxt = SCAN;
                    end
                end else if (bus.is_close) begin
                    if (stack_empty) begin
                        set_unf   = 1'b1;
                        state_nxt = ERR;
                        write_c   = bus.cell_zero;
                    end else if (!bus.cell_zero) begin
                        src_c = 1'b1;
                    end else begin
                        do_pop = 1'b1;
                    end
                end
            end
            SCAN: begin
                squash_c = 1'b1;
                if (bus.is_open) begin
                    if (depth == DEPTH_MAX) begin
                        set_ovf   = 1'b1;
                        state_nxt = ERR;
                    end else begin
                        depth_nxt = depth + SCAN_WIDTH'(1);
                    end
                end else if (bus.is_close) begin
                    depth_nxt = depth - SCAN_WIDTH'(1);
                    if (depth == SCAN_WIDTH'(1)) state_nxt = RUN;
                end
            end
            default: begin
                write_c  = 1'b0;
                squash_c = 1'b1;
            end
        endcase
    end

    // A stalled cycle still shows the pending decision; only the PC enable is withheld.
    always_comb begin
        bus.pc_write  = reset & write_c & ~bus.stall_in;
        bus.pc_src    = reset & src_c;
        bus.squash    = reset & squash_c;
        bus.pc_loaded = reset ? top : '0;
    end

    assign bus.loop_level = sp;
    assign bus.overflow   = overflow_r;
    assign bus.underflow  = underflow_r;
    assign bus.fsm_state  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            sp          <= '0;
            depth       <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (!bus.stall_in) begin
            state <= state_nxt;
            depth <= depth_nxt;
            if (do_push) sp <= sp + SP_WIDTH'(1);
            if (do_pop)  sp <= sp_m1;
            if (set_ovf) overflow_r  <= 1'b1;
            if (set_unf) underflow_r <= 1'b1;
        end
    end

    // Stack storage carries no reset; entries above sp are never observed.
    always_ff @(posedge clk) begin
        if (reset && !bus.stall_in && do_push) begin
            stack[sp[IDX_WIDTH-1:0]] <= bus.pc + PC_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_loop_controller.sv
// Bench for loop_controller: directed program walks plus randomized strobes, all checked
// every cycle against a queue-based behavioural model of the loop rules.
module tb_loop_controller;
    localparam int PW = 16;
    localparam int SD = 4;
    localparam int SW = 3;
    localparam int LW = $clog2(SD + 1);
    localparam int EW = 3 + PW + LW + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    loop_controller_if #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) bus ();

    loop_controller #(.PC_WIDTH(PW), .STACK_DEPTH(SD), .SCAN_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Behavioural model: mode 0 running, 1 skipping forward, 2 halted.
    int            m_mode;
    logic [PW-1:0] m_stk[$];
    int            m_depth;
    bit            m_ovf;
    bit            m_unf;
    logic [PW-1:0] pc_m;

    logic [EW-1:0] exp_q[$];
    int            n_cmp  = 0;
    int            n_fail = 0;

    logic [7:0]    prog [64];
    bit            prog_mode = 1'b0;

    logic          s_wr;
    logic          s_src;
    logic          s_sq;
    logic [PW-1:0] s_loaded;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_stk.delete();
        m_depth = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        pc_m    = '0;
    endtask

    task automatic load_prog(input string s);
        for (int i = 0; i < 64; i++) prog[i] = ".";
        for (int i = 0; i < s.len(); i++) prog[i] = s[i];
    endtask

    // Works out what the fetch unit must see for the presented instruction, queues it,
    // then advances the model (stack, nesting count, flags, fetch PC).
    task automatic model_step();
        bit            op, cl, z, st, wr, src, sq;
        int            lvl, mode_n, depth_n;
        bit            push_n, pop_n, ovf_n, unf_n;
        logic [PW-1:0] ld;
        op  = bus.is_open;
        cl  = bus.is_close && !bus.is_open;
        z   = bus.cell_zero;
        st  = bus.stall_in;
        lvl = m_stk.size();
        ld  = (lvl > 0) ? m_stk[lvl-1] : '0;
        wr = 1'b1; src = 1'b0; sq = 1'b0;
        mode_n = m_mode; depth_n = m_depth;
        push_n = 1'b0; pop_n = 1'b0; ovf_n = m_ovf; unf_n = m_unf;
        if (m_mode == 2) begin
            wr = 1'b0; sq = 1'b1;
        end else if (m_mode == 1) begin
            sq = 1'b1;
            if (op && m_depth == (1 << SW) - 1) begin
                ovf_n = 1'b1; mode_n = 2;
            end else if (op) begin
                depth_n = m_depth + 1;
            end else if (cl) begin
                depth_n = m_depth - 1;
                if (depth_n == 0) mode_n = 0;
            end
        end else if (op && z) begin
            sq = 1'b1; depth_n = 1; mode_n = 1;
        end else if (op) begin
            if (lvl < SD) push_n = 1'b1;
            else begin ovf_n = 1'b1; mode_n = 2; wr = 1'b0; end
        end else if (cl && lvl == 0) begin
            unf_n = 1'b1; mode_n = 2; wr = z;
        end else if (cl) begin
            if (z) pop_n = 1'b1;
            else src = 1'b1;
        end
        if (st) wr = 1'b0;
        if (!reset) begin
            wr = 1'b0; src = 1'b0; sq = 1'b0; ld = '0;
        end
        exp_q.push_back({wr, src, sq, ld, LW'(lvl), m_ovf, m_unf});
        if (reset && !st) begin
            m_mode = mode_n; m_depth = depth_n; m_ovf = ovf_n; m_unf = unf_n;
            if (push_n) m_stk.push_back(bus.pc + PW'(1));
            if (pop_n) void'(m_stk.pop_back());
            if (wr) pc_m = src ? ld : pc_m + PW'(1);
        end
    endtask

    task automatic compare();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        s_wr = bus.pc_write; s_src = bus.pc_src; s_sq = bus.squash; s_loaded = bus.pc_loaded;
        chk("pc_write",   32'(bus.pc_write),   32'(e[EW-1]));
        chk("pc_src",     32'(bus.pc_src),     32'(e[EW-2]));
        chk("squash",     32'(bus.squash),     32'(e[EW-3]));
        chk("pc_loaded",  32'(bus.pc_loaded),  32'(e[EW-4 -: PW]));
        chk("loop_level", 32'(bus.loop_level), 32'(e[LW+1:2]));
        chk("overflow",   32'(bus.overflow),   32'(e[1]));
        chk("underflow",  32'(bus.underflow),  32'(e[0]));
    endtask

    // Entered just after a rising edge; presents one instruction and checks at the falling edge.
    task automatic tick(input bit op, input bit cl, input bit z, input bit st);
        bus.pc = pc_m;
        if (prog_mode) begin
            bus.is_open  = (prog[pc_m[5:0]] == "[");
            bus.is_close = (prog[pc_m[5:0]] == "]");
        end else begin
            bus.is_open  = op;
            bus.is_close = cl;
        end
        bus.cell_zero = z;
        bus.stall_in  = st;
        @(negedge clk);
        model_step();
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        bus.pc = '0; bus.is_open = 1'b0; bus.is_close = 1'b0;
        bus.cell_zero = 1'b0; bus.stall_in = 1'b0;
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Taken loop with a stalled back-branch, forward skip, then reset mid-scan.
        load_prog("+[-][[+]-].[[+]]");
        prog_mode = 1'b1;
        do_reset();
        chk("rst_level", 32'(bus.loop_level), 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("tl_push_level", 32'(bus.loop_level), 1);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1);
            chk("st_wr", 32'(s_wr), 0);
            chk("st_src", 32'(s_src), 1);
            chk("st_loaded", 32'(s_loaded), 2);
            chk("st_pc", 32'(pc_m), 3);
            chk("st_level", 32'(bus.loop_level), 1);
        end
        tick(0, 0, 0, 0);
        chk("tl_src", 32'(s_src), 1);
        chk("tl_next_pc", 32'(pc_m), 2);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("tl_pop_level", 32'(bus.loop_level), 0);
        chk("tl_exit_pc", 32'(pc_m), 4);
        for (int i = 0; i < 6; i++) begin
            chk("fs_pc", 32'(pc_m), 4 + i);
            tick(0, 0, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 0);
            chk("fs_squash", 32'(s_sq), 1);
        end
        tick(0, 0, 0, 0);
        chk("fs_done_squash", 32'(s_sq), 0);
        chk("fs_done_level", 32'(bus.loop_level), 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        chk("ms_pc", 32'(pc_m), 13);
        #2 reset = 1'b0;
        #1;
        chk("ms_async_wr", 32'(bus.pc_write), 0);
        chk("ms_async_squash", 32'(bus.squash), 0);
        model_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        reset = 1'b1;
        prog_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            chk("ms_run_wr", 32'(s_wr), 1);
            chk("ms_run_sq", 32'(s_sq), 0);
        end
        chk("ms_run_pc", 32'(pc_m), 3);

        // Stack overflow with five nested taken loops.
        load_prog("[[[[[");
        prog_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
        chk("ov_level", 32'(bus.loop_level), 4);
        tick(0, 0, 0, 0);
        chk("ov_wr", 32'(s_wr), 0);
        chk("ov_flag", 32'(bus.overflow), 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0);
            chk("ov_hold_wr", 32'(s_wr), 0);
        end

        // Underflow on an unmatched taken ']'.
        load_prog("]");
        do_reset();
        tick(0, 0, 0, 0);
        chk("uf_wr", 32'(s_wr), 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, 0);
            chk("uf_hold_wr", 32'(s_wr), 0);
            chk("uf_hold_sq", 32'(s_sq), 1);
            chk("uf_hold_flag", 32'(bus.underflow), 1);
        end

        // Scan nesting counter saturation (SCAN_WIDTH=3 allows depth 7).
        load_prog("[[[[[[[[");
        do_reset();
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 0);
        chk("so_flag", 32'(bus.overflow), 1);
        chk("so_level", 32'(bus.loop_level), 0);

        // Randomized strobes with the model acting as fetch unit.
        prog_mode = 1'b0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (m_mode == 2 && $urandom_range(0, 7) == 0) begin
                do_reset();
            end else begin
                tick(1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 25),
                     1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 15));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
